// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM arbiter slice.
// Optional feature macro: VRAM_READBACK_EN (enables host reads).
package vram_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  // RAM-bus operation driven during the current cycle
  typedef enum logic [1:0] {IDLE, DISP_RD, HOST_WR, HOST_RD} state_e;

  // Owner of the read data returning from the RAM
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_e;

endpackage

// File: rtl/vram_arbiter_host_req_slot.sv
// One-entry holding register for host requests. Ready only when empty, so a
// request can never be accepted on the same edge the previous one issues.
module host_req_slot
  import vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_we_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  output logic              out_valid_o,
  input  logic              out_pop_i,
  output logic              out_we_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_wdata_o
);

  logic              full_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign in_ready_o  = ~full_q;
  assign out_valid_o = full_q;
  assign out_we_o    = we_q;
  assign out_addr_o  = addr_q;
  assign out_wdata_o = wdata_q;

  // Fill on accept, drain when the arbiter issues the entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (in_valid_i && !full_q) begin
      full_q  <= 1'b1;
      we_q    <= in_we_i;
      addr_q  <= in_addr_i;
      wdata_q <= in_wdata_i;
    end else if (out_pop_i) begin
      full_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, host requests fill
// idle cycles from a one-entry slot. Read data returns two edges after the
// request is sampled, steered by a tag that follows the bus state.
// Optional feature macro: VRAM_READBACK_EN (host reads; otherwise write-only host).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_starve,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic              slot_full, slot_we, slot_pop, slot_in_we;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;

  state_e            state_q, state_d;
  tag_e              tag_q, tag_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        wait_q, wait_d;
  logic              starve_q, starve_d;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

`ifdef VRAM_READBACK_EN
  assign slot_in_we = host_we;
`else
  // Host port is write-only in this build; the direction input is ignored.
  logic unused_host_we;
  assign unused_host_we = host_we;
  assign slot_in_we     = 1'b1;
`endif

  host_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (host_valid),
    .in_ready_o  (host_ready),
    .in_we_i     (slot_in_we),
    .in_addr_i   (host_addr),
    .in_wdata_i  (host_wdata),
    .out_valid_o (slot_full),
    .out_pop_i   (slot_pop),
    .out_we_o    (slot_we),
    .out_addr_o  (slot_addr),
    .out_wdata_o (slot_wdata)
  );

  // Arbitration: pick next bus op, return tag, and starvation bookkeeping
  always_comb begin
    state_d     = IDLE;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    slot_pop    = 1'b0;
    if (disp_req) begin
      state_d    = DISP_RD;
      ram_addr_d = disp_addr;
    end else if (slot_full) begin
      slot_pop   = 1'b1;
      ram_addr_d = slot_addr;
      if (slot_we) begin
        state_d     = HOST_WR;
        ram_we_d    = 1'b1;
        ram_wdata_d = slot_wdata;
      end else begin
        state_d = HOST_RD;
      end
    end

    // The op on the bus now returns data next cycle; remember its owner.
    case (state_q)
      DISP_RD: tag_d = TAG_DISP;
      HOST_RD: tag_d = TAG_HOST;
      default: tag_d = TAG_NONE;
    endcase

    wait_d = wait_q;
    if (slot_pop)                                 wait_d = '0;
    else if (slot_full && disp_req && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
    starve_d = starve_q | (wait_d >= MAX_WAIT_C);
  end

  // Bus, tag and starvation state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= TAG_NONE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      wait_q      <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
    end
  end

  // Display return register: capture RAM data when the tag says it is ours
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      disp_valid_q <= (tag_q == TAG_DISP);
      if (tag_q == TAG_DISP) disp_data_q <= ram_rdata;
    end
  end

`ifdef VRAM_READBACK_EN
  logic              host_rvalid_q;
  logic [DATA_W-1:0] host_rdata_q;

  // Host return register, same timing as the display path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      host_rvalid_q <= (tag_q == TAG_HOST);
      if (tag_q == TAG_HOST) host_rdata_q <= ram_rdata;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
`else
  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

  assign disp_valid  = disp_valid_q;
  assign disp_data   = disp_data_q;
  assign host_starve = starve_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected returns and
// RAM writes (with the cycle they must appear); a negedge monitor pops them.
module tb_vram_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          host_valid, host_ready, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_rvalid, host_starve;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata = '0;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(64)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_starve(host_starve),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: read data is the address, one cycle after ram_addr
  always @(posedge clk) ram_rdata <= {1'b0, ram_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int c; } rd_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int c; } wr_t;
  rd_t dq[$];
  rd_t hq[$];
  wr_t wq[$];

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a display fetch sampled at the next edge; data due two edges later
  task automatic disp_issue(input logic [AW-1:0] a);
    rd_t e;
    disp_req  = 1'b1;
    disp_addr = a;
    e.data = {1'b0, a};
    e.c    = cyc + 3;
    dq.push_back(e);
  endtask

  // Monitor
  rd_t mr;
  wr_t mw;
  always @(negedge clk) begin
    if (!rst) begin
      if (disp_valid) begin
        if (dq.size() == 0) check("disp_unexpected", 1, 0);
        else begin
          mr = dq.pop_front();
          check("disp_data", disp_data, mr.data);
          check("disp_cycle", cyc, mr.c);
        end
      end
      if (host_rvalid) begin
        if (hq.size() == 0) check("host_rvalid_unexpected", 1, 0);
        else begin
          mr = hq.pop_front();
          check("host_rdata", host_rdata, mr.data);
          check("host_rcycle", cyc, mr.c);
        end
      end
      if (ram_we) begin
        if (wq.size() == 0) check("ram_we_unexpected", 1, 0);
        else begin
          mw = wq.pop_front();
          check("wr_addr", ram_addr, mw.addr);
          check("wr_data", ram_wdata, mw.data);
          check("wr_cycle", cyc, mw.c);
        end
      end
    end
  end

  initial begin
    int a;
    wr_t w;
    rd_t h;
    rst = 1'b1; disp_req = 0; disp_addr = '0;
    host_valid = 0; host_we = 1; host_addr = '0; host_wdata = '0;
    tick();
    check("por_bus", {ram_we, ram_addr, ram_wdata}, 0);
    check("por_ready", host_ready, 1);
    rst = 1'b0;
    tick();

    // 1: async reset in the middle of a write
    host_valid = 1; host_we = 1; host_addr = 15'h0AAA; host_wdata = 16'h1234;
    tick();
    host_valid = 0;
    tick();
    check("t1_we_before_rst", {ram_we, ram_addr, ram_wdata}, {1'b1, 15'h0AAA, 16'h1234});
    rst = 1'b1;
    #1;
    check("t1_rst_bus", {ram_we, ram_addr, ram_wdata}, 0);
    check("t1_rst_ret", {disp_valid, disp_data, host_rvalid, host_rdata, host_starve}, 0);
    check("t1_rst_ready", host_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // 2: single display fetch
    disp_issue(15'h0123);
    tick();
    disp_req = 0;
    repeat (3) tick();

    // 3: host write with display idle
    host_valid = 1; host_we = 1; host_addr = 15'h4000; host_wdata = 16'hBEEF;
    tick();
    a = cyc;
    host_valid = 0;
    check("t3_ready_low", host_ready, 0);
    w.addr = 15'h4000; w.data = 16'hBEEF; w.c = a + 1;
    wq.push_back(w);
    tick();
    check("t3_ready_back", host_ready, 1);
    repeat (2) tick();

    // 4: host pending behind 10 display fetches
    host_valid = 1; host_addr = 15'h0200; host_wdata = 16'hA5A5;
    tick();
    a = cyc;
    host_valid = 0;
    w.addr = 15'h0200; w.data = 16'hA5A5; w.c = a + 11;
    wq.push_back(w);
    for (int i = 0; i < 10; i++) begin
      disp_issue(15'(16'h0300 + i));
      tick();
      check("t4_ready_held", host_ready, 0);
    end
    disp_req = 0;
    tick();
    check("t4_ready_after", host_ready, 1);
    check("t4_starve", host_starve, 0);
    repeat (3) tick();

    // 5: starvation at 64 waiting cycles, sticky until reset
    host_valid = 1; host_addr = 15'h0400; host_wdata = 16'hC0DE;
    tick();
    a = cyc;
    host_valid = 0;
    w.addr = 15'h0400; w.data = 16'hC0DE; w.c = a + 71;
    wq.push_back(w);
    for (int i = 0; i < 70; i++) begin
      disp_issue(15'(16'h1000 + i));
      tick();
      if (i == 62) check("t5_starve_at63", host_starve, 0);
      if (i == 63) check("t5_starve_at64", host_starve, 1);
    end
    disp_req = 0;
    repeat (4) tick();
    check("t5_starve_sticky", host_starve, 1);
    rst = 1'b1;
    #1;
    check("t5_starve_rst", host_starve, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef VRAM_READBACK_EN
    // 6: host read interleaved with two display reads
    host_valid = 1; host_we = 0; host_addr = 15'h0010;
    tick();
    a = cyc;
    host_valid = 0; host_we = 1;
    h.data = 16'h0010; h.c = a + 4;
    hq.push_back(h);
    disp_issue(15'h0011);
    tick();
    disp_req = 0;
    tick();
    disp_issue(15'h0012);
    tick();
    disp_req = 0;
    repeat (4) tick();
`else
    // 6: direction input ignored, a "read" request becomes a write
    host_valid = 1; host_we = 0; host_addr = 15'h0050; host_wdata = 16'h5555;
    tick();
    a = cyc;
    host_valid = 0; host_we = 1;
    w.addr = 15'h0050; w.data = 16'h5555; w.c = a + 1;
    wq.push_back(w);
    repeat (4) tick();
`endif

    repeat (4) tick();
    check("drain_disp", dq.size(), 0);
    check("drain_host", hq.size(), 0);
    check("drain_wr", wq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
